// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit for a 5-stage in-order pipeline.
// Tracks EX/MEM/WB destination info and drives forwarding selects, stall, flush and a stall counter.
module fwd_hazard_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ID_VALID,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_RS1_USED,
  input  logic             ID_RS2_USED,
  input  logic [4:0]       ID_RD,
  input  logic             ID_REGWRITE,
  input  logic             ID_MEMREAD,
  input  logic             BR_TAKEN,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic             STALL,
  output logic             FLUSH,
  output logic [CNT_W-1:0] STALL_CNT
);

  // Load status only influences the load-use check while in EX, so MEM/WB carry just producer info.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
  } dst_t;

  typedef struct packed {
    dst_t       dst;
    logic       memread;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
  } ex_t;

  ex_t  ex_q, ex_d;
  dst_t mem_q, wb_q;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic writes(input dst_t s, input logic [4:0] r);
    return s.valid && s.regwrite && (s.rd != '0) && (s.rd == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] r,
                                         input logic ex_valid, input dst_t mem_s,
                                         input dst_t wb_s);
    logic [1:0] sel;
    sel = 2'd0;
    if (ex_valid && used) begin
      if (writes(mem_s, r))
        sel = 2'd1;
      else if (writes(wb_s, r))
        sel = 2'd2;
    end
    return sel;
  endfunction

  always_comb begin
    FWD_A_SEL = fwd_sel(ex_q.rs1_used, ex_q.rs1, ex_q.dst.valid, mem_q, wb_q);
    FWD_B_SEL = fwd_sel(ex_q.rs2_used, ex_q.rs2, ex_q.dst.valid, mem_q, wb_q);
  end

  always_comb begin
    FLUSH = BR_TAKEN;
    STALL = 1'b0;
    if (ID_VALID && !BR_TAKEN && ex_q.dst.valid && ex_q.memread && (ex_q.dst.rd != '0)) begin
      if ((ID_RS1_USED && (ID_RS1 == ex_q.dst.rd)) ||
          (ID_RS2_USED && (ID_RS2 == ex_q.dst.rd)))
        STALL = 1'b1;
    end
  end

  always_comb begin
    ex_d = '0;
    if (!STALL && !FLUSH) begin
      ex_d.dst.valid    = ID_VALID;
      ex_d.dst.rd       = ID_RD;
      ex_d.dst.regwrite = ID_REGWRITE;
      ex_d.memread      = ID_MEMREAD;
      ex_d.rs1          = ID_RS1;
      ex_d.rs2          = ID_RS2;
      ex_d.rs1_used     = ID_RS1_USED;
      ex_d.rs2_used     = ID_RS2_USED;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q.dst;
      wb_q  <= mem_q;
      if (STALL && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign STALL_CNT = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: history-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fwd_hazard_unit;

  localparam int unsigned CW = 2;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } ins_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  ins_t          id  = '0;
  logic          br  = 1'b0;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall, flush;
  logic [CW-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  fwd_hazard_unit #(.CNT_W(CW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ID_VALID   (id.v),
    .ID_RS1     (id.rs1),
    .ID_RS2     (id.rs2),
    .ID_RS1_USED(id.u1),
    .ID_RS2_USED(id.u2),
    .ID_RD      (id.rd),
    .ID_REGWRITE(id.rw),
    .ID_MEMREAD (id.mr),
    .BR_TAKEN   (br),
    .FWD_A_SEL  (fwd_a),
    .FWD_B_SEL  (fwd_b),
    .STALL      (stall),
    .FLUSH      (flush),
    .STALL_CNT  (stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // hist[0] is the instruction that most recently entered EX, hist[1] the one before, etc.
  ins_t hist [3];
  int   m_cnt;
  logic model_ok = 1'b0;

  function automatic bit producer_of(input ins_t p, input logic [4:0] r);
    return p.v && p.rw && p.rd != 0 && p.rd == r;
  endfunction

  function automatic int exp_sel(input bit used, input logic [4:0] r);
    if (!hist[0].v || !used) return 0;
    if (producer_of(hist[1], r)) return 1;
    if (producer_of(hist[2], r)) return 2;
    return 0;
  endfunction

  function automatic bit exp_stall();
    ins_t l;
    l = hist[0];
    if (!id.v || br || !l.v || !l.mr || l.rd == 0) return 0;
    return (id.u1 && id.rs1 == l.rd) || (id.u2 && id.rs2 == l.rd);
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      hist[0]  <= '0;
      hist[1]  <= '0;
      hist[2]  <= '0;
      m_cnt    <= 0;
      model_ok <= 1'b1;
    end else if (model_ok) begin
      hist[0] <= (exp_stall() || br) ? '0 : id;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      if (exp_stall())
        m_cnt <= (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
    end
  end

  always @(negedge CLK) begin
    if (model_ok && !RST) begin
      chk("model_fwd_a", 32'(fwd_a), 32'(exp_sel(hist[0].u1, hist[0].rs1)));
      chk("model_fwd_b", 32'(fwd_b), 32'(exp_sel(hist[0].u2, hist[0].rs2)));
      chk("model_stall", 32'(stall), 32'(exp_stall()));
      chk("model_flush", 32'(flush), 32'(br));
      chk("model_cnt",   32'(stall_cnt), 32'(m_cnt));
    end
  end

  function automatic ins_t mk(input bit v, input int rd, input bit rw, input bit mr,
                              input int rs1, input int rs2, input bit u1, input bit u2);
    ins_t i;
    i.v = v; i.rd = 5'(rd); i.rw = rw; i.mr = mr;
    i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.u1 = u1; i.u2 = u2;
    return i;
  endfunction

  task automatic issue(input ins_t i, input logic b);
    @(posedge CLK);
    #1;
    id = i;
    br = b;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    id  = '0;
    br  = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    ins_t nop, cons, lw7;
    int lit_cnt [4];
    lit_cnt = '{1, 2, 3, 3};
    nop  = '0;
    lw7  = mk(1, 7, 1, 1, 0, 0, 0, 0);

    do_reset();
    @(negedge CLK);
    chk("rst_fwd_a", 32'(fwd_a), 0);
    chk("rst_fwd_b", 32'(fwd_b), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_cnt",   32'(stall_cnt), 0);
    issue(nop, 1'b1);
    @(negedge CLK);
    chk("rst_flush", 32'(flush), 1);

    // add x5 ; add rs1=x5 -> MEM forward
    issue(mk(1, 5, 1, 0, 1, 2, 1, 1), 1'b0);
    issue(mk(1, 6, 1, 0, 5, 0, 1, 0), 1'b0);
    issue(nop, 1'b0);
    @(negedge CLK);
    chk("mem_fwd_a", 32'(fwd_a), 1);
    // add x5 ; gap ; add rs1=x5 -> WB forward
    issue(mk(1, 5, 1, 0, 1, 2, 1, 1), 1'b0);
    issue(nop, 1'b0);
    issue(mk(1, 6, 1, 0, 5, 0, 1, 0), 1'b0);
    issue(nop, 1'b0);
    @(negedge CLK);
    chk("wb_fwd_a", 32'(fwd_a), 2);

    // load-use on rs2 = x7
    do_reset();
    cons = mk(1, 8, 1, 0, 1, 7, 1, 1);
    issue(lw7, 1'b0);
    issue(cons, 1'b0);
    @(negedge CLK);
    chk("lu_stall", 32'(stall), 1);
    chk("lu_cnt0",  32'(stall_cnt), 0);
    issue(cons, 1'b0);
    @(negedge CLK);
    chk("lu_stall_once", 32'(stall), 0);
    chk("lu_cnt1",       32'(stall_cnt), 1);
    issue(nop, 1'b0);
    @(negedge CLK);
    chk("lu_fwd_b", 32'(fwd_b), 2);

    // load-use coincident with a taken branch
    issue(mk(1, 9, 1, 1, 0, 0, 0, 0), 1'b0);
    issue(mk(1, 10, 1, 0, 9, 0, 1, 0), 1'b1);
    @(negedge CLK);
    chk("br_stall", 32'(stall), 0);
    chk("br_flush", 32'(flush), 1);
    issue(mk(1, 11, 1, 0, 9, 0, 1, 0), 1'b0);
    @(negedge CLK);
    chk("br_bubble_fwd_a", 32'(fwd_a), 0);
    chk("br_cnt",          32'(stall_cnt), 1);

    // two producers of x3, youngest wins on both operands
    issue(mk(1, 3, 1, 0, 0, 0, 0, 0), 1'b0);
    issue(mk(1, 3, 1, 0, 0, 0, 0, 0), 1'b0);
    issue(mk(1, 4, 1, 0, 3, 3, 1, 1), 1'b0);
    issue(nop, 1'b0);
    @(negedge CLK);
    chk("prio_fwd_a", 32'(fwd_a), 1);
    chk("prio_fwd_b", 32'(fwd_b), 1);

    // x0 is never a hazard, even for a load
    issue(mk(1, 0, 1, 1, 0, 0, 0, 0), 1'b0);
    issue(mk(1, 4, 1, 0, 0, 0, 1, 1), 1'b0);
    @(negedge CLK);
    chk("x0_stall", 32'(stall), 0);
    issue(nop, 1'b0);
    @(negedge CLK);
    chk("x0_fwd_a", 32'(fwd_a), 0);
    chk("x0_fwd_b", 32'(fwd_b), 0);

    // counter saturation with CNT_W=2
    do_reset();
    for (int k = 0; k < 4; k++) begin
      issue(lw7, 1'b0);
      issue(cons, 1'b0);
      issue(cons, 1'b0);
      @(negedge CLK);
      chk($sformatf("sat_cnt%0d", k), 32'(stall_cnt), 32'(lit_cnt[k]));
    end
    do_reset();
    @(negedge CLK);
    chk("sat_cnt_rst", 32'(stall_cnt), 0);

    // reset arriving while a stall is being shown
    issue(lw7, 1'b0);
    issue(cons, 1'b0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_cnt",   32'(stall_cnt), 0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      @(posedge CLK);
      #1;
      RST = ($urandom_range(0, 63) == 0);
      id  = mk($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
               $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 9) == 0);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    id  = '0;
    br  = 1'b0;
    @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 ID_VALID  in  1  decode stage holds a real instruction.
REQ-005 ID_RS1, ID_RS2  in  5 each  decode-stage source register indices.
REQ-006 ID_RS1_USED, ID_RS2_USED  in  1 each  decode instruction actually reads that source.
REQ-007 ID_RD  in  5  decode-stage destination index.
REQ-008 ID_REGWRITE  in  1  decode instruction writes ID_RD.
REQ-009 ID_MEMREAD  in  1  decode instruction is a load.
REQ-010 BR_TAKEN  in  1  EX-stage control transfer taken this cycle.
REQ-011 FWD_A_SEL, FWD_B_SEL  out  2 each  operand select for the EX rs1/rs2 3:1 muxes: 0 = register file, 1 = MEM-stage result, 2 = WB-stage result; 3 is never driven.
REQ-012 STALL  out  1  hold PC and IF/ID this cycle.
REQ-013 FLUSH  out  1  squash the IF/ID instruction this cycle.
REQ-014 STALL_CNT  out  CNT_W  saturating count of stall cycles.

Function
REQ-015 The unit SHALL keep three internal slots, EX, MEM and WB, each holding valid, rd, regwrite, memread; the EX slot also holds rs1, rs2, rs1_used, rs2_used.
REQ-016 Every non-reset clock: WB <= MEM, MEM <= EX.
REQ-017 EX SHALL load the decode fields (valid = ID_VALID) when STALL=0 and FLUSH=0; otherwise EX SHALL load a bubble (valid=0, regwrite=0, memread=0).
REQ-018 A slot "writes r" when valid=1, regwrite=1, rd!=0 and rd==r.
REQ-019 FWD_A_SEL SHALL be 1 if EX.rs1_used and MEM writes EX.rs1; else 2 if EX.rs1_used and WB writes EX.rs1; else 0. FWD_B_SEL identical using rs2.
REQ-020 MEM match SHALL take priority over WB match (youngest producer wins).
REQ-021 FWD_*_SEL SHALL be 0 whenever EX.valid=0, and for register x0 in all cases.
REQ-022 FWD_*_SEL are combinational from slot registers only: zero added latency, valid in the same cycle the consumer sits in EX.
REQ-023 STALL SHALL be 1 when ID_VALID=1, BR_TAKEN=0, EX.valid=1, EX.memread=1, EX.rd!=0, and (ID_RS1_USED and ID_RS1==EX.rd, or ID_RS2_USED and ID_RS2==EX.rd); else 0.
REQ-024 A load-use hazard SHALL produce exactly one STALL cycle; on the next cycle the load is in MEM and the consumer re-evaluates without stall, receiving FWD sel 2 in EX.
REQ-025 FLUSH SHALL equal BR_TAKEN combinationally; BR_TAKEN overrides STALL (STALL=0, bubble into EX).
REQ-026 The branching instruction in EX SHALL still advance to MEM on a BR_TAKEN cycle.
REQ-027 STALL_CNT SHALL increment by 1 on each clock edge where STALL=1, and SHALL hold at 2^CNT_W-1 without wrapping.
REQ-028 Decode-vs-WB same-cycle hazards are not forwarded by this unit; the register file write-through covers them.

Reset
REQ-029 While RST=1 at a clock edge, all slots SHALL clear to bubbles and STALL_CNT to 0.
REQ-030 After reset, FWD_A_SEL=FWD_B_SEL=0, STALL=0 (slots empty), FLUSH follows BR_TAKEN.
REQ-031 RST asserted mid-stall SHALL discard the hazard; the first post-reset cycle shows STALL=0 unless a new hazard is presented.

Verification
REQ-032 add x5 then dependent add rs1=x5 next cycle -> FWD_A_SEL=1 with consumer in EX; one cycle later with gap instr -> FWD_A_SEL=2.
REQ-033 lw x7 followed by add rs2=x7 -> STALL=1 for exactly one cycle, STALL_CNT 0->1, then FWD_B_SEL=2 with consumer in EX.
REQ-034 Two producers of x3 in MEM and WB, consumer rs1=rs2=x3 -> FWD_A_SEL=FWD_B_SEL=1.
REQ-035 Producer writes x0, consumer reads x0 -> both sels 0, STALL=0 even if producer is a load.
REQ-036 Load-use hazard coincident with BR_TAKEN=1 -> STALL=0, FLUSH=1, bubble in EX next cycle, STALL_CNT unchanged.
REQ-037 CNT_W=2, four forced load-use stalls -> STALL_CNT reads 1,2,3,3; RST then -> 0.
